// File: rtl/dmem_pkg.sv
// dmem_pkg: shared data-memory access codes, arbiter state encoding and size helper.
package dmem_pkg;

  localparam logic [2:0] MEM_SB  = 3'b000;
  localparam logic [2:0] MEM_SH  = 3'b001;
  localparam logic [2:0] MEM_SW  = 3'b010;
  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_LBU = 3'b100;
  localparam logic [2:0] MEM_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Bytes touched by an access; unknown size codes are treated as a full word.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3)
      MEM_LB, MEM_LBU: return 3'd1;
      MEM_LH, MEM_LHU: return 3'd2;
      default:         return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-input grant picker (round-robin or fixed priority, with lock override).
module rr_pick2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,
  input  logic       lock_ok,
  input  logic       mode,
  output logic [1:0] grant
);

  // On contention the port other than last_grant wins, unless fixed priority favours port 0.
  always_comb
    grant = lock_ok ? 2'b10 :
            (req0 && req1) ? ((mode || last_grant) ? 2'b01 : 2'b10) :
            {req1, req0};

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises two request ports onto the single-port data memory.
// Each access runs IDLE (select) -> ACCESS (strobes) -> RESP (ack) from registered outputs.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int PRIO_MODE = 0,
  parameter int MAX_LOCK  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [2:0]  funct3_0,
  input  logic [2:0]  funct3_1,
  input  logic        lock1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_read_data
);

  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(MAX_LOCK);

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          grant_q, grant_d;
  logic          err_pend_q, err_pend_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [2:0]    mem_f3_q, mem_f3_d;

  logic [1:0]  grant;
  logic        sel1, lock_ok, oor;
  logic        c_we;
  logic [31:0] c_addr, c_wdata;
  logic [2:0]  c_f3;
  logic [32:0] end_addr;

  assign lock_ok = lock1 && last_grant_q && req1 && (lock_cnt_q < LOCK_MAX);

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .lock_ok    (lock_ok),
    .mode       (PRIO_MODE != 0),
    .grant      (grant)
  );

  assign sel1    = grant[1];
  assign c_we    = sel1 ? we1 : we0;
  assign c_addr  = sel1 ? addr1 : addr0;
  assign c_wdata = sel1 ? wdata1 : wdata0;
  assign c_f3    = sel1 ? funct3_1 : funct3_0;

  // One extra bit so an access wrapping past 2^32 is still caught as out of range.
  assign end_addr = {1'b0, c_addr} + 33'(access_size(c_f3)) - 33'd1;
  assign oor      = end_addr >= 33'(MEM_BYTES);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_cnt_d   = lock_cnt_q;
    grant_d      = grant_q;
    err_pend_d   = err_pend_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = err0_q;
    err1_d       = err1_q;
    rdata_d      = rdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_f3_d     = mem_f3_q;
    case (state_q)
      ST_IDLE: if (|grant) begin
        state_d      = ST_ACCESS;
        grant_d      = sel1;
        last_grant_d = sel1;
        mem_addr_d   = c_addr;
        mem_wdata_d  = c_wdata;
        mem_f3_d     = c_f3;
        mem_read_d   = !oor && !c_we;
        mem_write_d  = !oor && c_we;
        err_pend_d   = oor;
        lock_cnt_d   = (!sel1 || !lock1) ? '0 :
                       (lock_ok && req0) ? lock_cnt_q + 1'b1 : lock_cnt_q;
      end
      ST_ACCESS: begin
        state_d     = ST_RESP;
        rdata_d     = mem_read_q ? mem_read_data : '0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        ack0_d      = !grant_q;
        ack1_d      = grant_q;
        err0_d      = !grant_q && err_pend_q;
        err1_d      = grant_q && err_pend_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      lock_cnt_q   <= '0;
      grant_q      <= 1'b0;
      err_pend_q   <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_f3_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
      grant_q      <= grant_d;
      err_pend_q   <= err_pend_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata_q      <= rdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_f3_q     <= mem_f3_d;
    end

  assign ack0           = ack0_q;
  assign ack1           = ack1_q;
  assign err0           = err0_q;
  assign err1           = err1_q;
  assign rdata          = rdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_address    = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_funct3     = mem_f3_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter/sequencer in front of the single-port byte-addressed data memory.
- Port 0 is the core load/store unit; port 1 is the FFT accelerator/DMA engine.
- Serialises requests, drives the memory command signals from registers, captures load data, and returns a one-cycle ack per access.
- Supports round-robin or fixed priority, bounded burst lock for port 1, and an address range check.

Parameters:
- MEM_BYTES, 1024: memory size in bytes; used for the range check.
- PRIO_MODE, 0: 0 = round-robin; 1 = fixed priority, port 0 wins.
- MAX_LOCK, 8: maximum consecutive locked port-1 grants while port 0 waits.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req0, req1  in  1  access request; held with a stable command until the matching ack.
- we0, we1  in  1  1 = store, 0 = load.
- addr0, addr1  in  32  byte address.
- wdata0, wdata1  in  32  store data.
- funct3_0, funct3_1  in  3  RISC-V load/store size code (SB/SH/SW/LB/LH/LW/LBU/LHU).
- lock1  in  1  port 1 requests burst continuation.
- ack0, ack1  out  1  one-cycle completion pulse.
- err0, err1  out  1  valid with ack; out-of-range access.
- rdata  out  32  load result; valid with ack.
- mem_read  out  1  to memory.
- mem_write  out  1  to memory.
- mem_address  out  32  to memory.
- mem_write_data  out  32  to memory.
- mem_funct3  out  3  to memory.
- mem_read_data  in  32  combinational read data from memory.

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, last_grant=1 (so port 0 wins first contention), lock_cnt=0.
  - Reset mid-access clears mem_write before the next edge, so an in-flight store is not performed and no ack is issued.
- State IDLE: if no req, stay. Otherwise select a winner:
  - PRIO_MODE=1: port 0 wins whenever req0=1.
  - PRIO_MODE=0: single requester wins; on contention the port not equal to last_grant wins.
  - Lock override: if lock1=1, last_grant=1, req1=1 and lock_cnt<MAX_LOCK, port 1 wins even against req0.
  - Latch the winner's command into the mem_* registers and set last_grant. Go to ACCESS.
- Range check (at selection): size = 1/2/4 bytes from funct3[1:0]. Out of range when addr+size-1 >= MEM_BYTES.
  - Out of range: mem_read and mem_write stay 0 and err is flagged.
  - In range: mem_read = ~we, mem_write = we.
- State ACCESS (exactly one cycle): memory strobes are active. The store commits at the end of this cycle.
  - At the edge: rdata <= mem_read_data for an in-range load, else 0. Clear mem_read and mem_write. Go to RESP.
- State RESP (one cycle): ack of the winner = 1, err of the winner valid, rdata valid.
  - Requests are not sampled in RESP. The requester updates or drops req at the edge ending RESP.
  - Go to IDLE.
- Latency and throughput: ack is asserted 2 cycles after the IDLE sampling edge. Throughput is one access per 3 cycles. mem_* strobes never assert in IDLE or RESP.
- lock_cnt:
  - Increments when port 1 wins via lock override while req0=1.
  - Resets to 0 when port 0 is granted or lock1=0 at selection.
  - Saturates at MAX_LOCK. Once saturated, the next contention goes to port 0.
- Simultaneous events: req dropped without ack is a protocol violation; the arbiter still completes the latched access. ack0 and ack1 are never both 1.
- rdata, err0 and err1 hold their values until the next RESP. ack is a single-cycle pulse.

Decomposition:
- Shared package dmem_pkg:
  - MEM_SB/SH/SW and MEM_LB/LH/LW/LBU/LHU funct3 constants, shared with data_memory and the core.
  - State encoding IDLE/ACCESS/RESP.
  - Helper function access_size(funct3).
- Sub-module rr_pick2: a combinational two-input picker taking req0, req1, last_grant, lock_ok and mode, producing a one-hot grant. This keeps the policy separately testable.

Test Plan:
- Single port-0 SW to addr 0x10 with wdata 0xDEADBEEF, then LW from 0x10 -> mem_write pulses one cycle; ack0 at +2 cycles; the LW returns rdata=0xDEADBEEF with err0=0.
- req0 and req1 asserted together from reset, both held with new commands after each ack, PRIO_MODE=0 -> grants alternate 0,1,0,1; ack0 and ack1 are never coincident.
- PRIO_MODE=0, lock1=1 with req1 and req0 continuously asserted, MAX_LOCK=8 -> 1 port-0 grant, then 9 port-1 grants (1 plain + 8 locked), then port 0 is granted.
- Port-1 LH at addr 0x3FF with MEM_BYTES=1024 -> no mem strobe; ack1 with err1=1 and rdata=0. LB at 0x3FF -> err1=0.
- Port-1 LB from a byte holding 0x80 -> rdata=0xFFFFFF80. LBU from the same byte -> rdata=0x00000080.
- Assert rst=0 asynchronously during ACCESS of an SW to 0x20 -> mem_write drops immediately; the location is unchanged; no ack; the state is IDLE after release.
